// File: rtl/count_updown_mod.sv
// Parametrised up/down modulo counter with enable, synchronous load and a registered wrap pulse.
// Define COUNT_UPDOWN_SAT_EN to make the count saturate at its limits instead of wrapping.
module count_updown_mod #(
  parameter int     WIDTH     = 4,
  parameter longint MODULUS   = 10,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             wrap,
  output logic             at_term
);

  // Terminal compares are done on WIDTH-bit values so MODULUS == 2**WIDTH never needs a WIDTH+1 bit.
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);
  localparam logic [63:0]      MOD_U     = 64'(MODULUS);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_badWidth
      $error("count_updown_mod: WIDTH must be in 2..32");
    end
    if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_badModulus
      $error("count_updown_mod: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_badResetVal
      $error("count_updown_mod: RESET_VAL must be below MODULUS");
    end
  endgenerate

  logic [WIDTH-1:0] r_counter;
  logic             r_wrap;
  logic [WIDTH-1:0] w_nextCount;
  logic             w_nextWrap;
  logic             w_atMax;
  logic             w_atZero;
  logic             w_loadInRange;

  assign w_atMax       = (r_counter == MAX_VAL);
  assign w_atZero      = (r_counter == '0);
  assign w_loadInRange = ({{(64-WIDTH){1'b0}}, load_val} < MOD_U);

  always_comb begin
    w_nextCount = r_counter;
    w_nextWrap  = 1'b0;
    if (load) begin
      w_nextCount = w_loadInRange ? load_val : MAX_VAL;
    end else if (en) begin
      if (up_dn) begin
`ifdef COUNT_UPDOWN_SAT_EN
        // Pulse only on the step that arrives at the limit; sitting there stays quiet.
        if (!w_atMax) begin
          w_nextCount = r_counter + WIDTH'(1);
          w_nextWrap  = ((r_counter + WIDTH'(1)) == MAX_VAL);
        end
`else
        if (w_atMax) begin
          w_nextCount = '0;
          w_nextWrap  = 1'b1;
        end else begin
          w_nextCount = r_counter + WIDTH'(1);
        end
`endif
      end else begin
`ifdef COUNT_UPDOWN_SAT_EN
        if (!w_atZero) begin
          w_nextCount = r_counter - WIDTH'(1);
          w_nextWrap  = (r_counter == WIDTH'(1));
        end
`else
        if (w_atZero) begin
          w_nextCount = MAX_VAL;
          w_nextWrap  = 1'b1;
        end else begin
          w_nextCount = r_counter - WIDTH'(1);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_counter <= RESET_CNT;
      r_wrap    <= 1'b0;
    end else begin
      r_counter <= w_nextCount;
      r_wrap    <= w_nextWrap;
    end
  end

  assign counter = r_counter;
  assign wrap    = r_wrap;
  assign at_term = up_dn ? w_atMax : w_atZero;

endmodule
